cpu_control_fsm: RTL

- Multi-cycle control unit for the 16-bit CPU.
- Sequences fetch, decode, execute, memory and writeback for the PC, instruction register, register file, ALU and the shared single-port RAM.
- Sits between the latched instruction word and the datapath enables. Replaces free-running PC stepping with an explicit state machine that stalls on memory and supports halt and resume.

---
 rtl/cpu_control_fsm.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU.
// Sequences fetch/decode/execute/memory/writeback, stalls on RAM, and
// supports halt/trap with run-pulse resume. Outputs are decoded from the
// current state and the opcode latched in DECODE.
module cpu_control_fsm #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     instr,
    input  logic            mem_ready,
    input  logic            alu_zero,
    input  logic            run,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic [1:0]      alu_op,
    output logic [2:0]      state,
    output logic            halted,
    output logic            trap,
    output logic [CNTW-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_NOP = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_AND = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_LDI = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_LD  = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_ST  = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_BZ  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    state_t          state_q;
    state_t          state_d;
    logic [OPW-1:0]  opc_q;
    logic [CNTW-1:0] retired_q;
    logic            retire_evt;
    logic [OPW-1:0]  dec_op;

    assign dec_op = instr[15 -: OPW];

    // Opcodes that decode into a real instruction (HLT included).
    function automatic logic is_legal(input logic [OPW-1:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_LDI,
            OP_LD, OP_ST, OP_JMP, OP_BZ, OP_HLT: is_legal = 1'b1;
            default:                             is_legal = 1'b0;
        endcase
    endfunction

    // ALU function for arithmetic/logic opcodes; everything else uses ADD.
    function automatic logic [1:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            OP_SUB:  alu_code = 2'b01;
            OP_AND:  alu_code = 2'b10;
            default: alu_code = 2'b00;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Opcode is captured once per instruction while in DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  opc_q <= OP_NOP;
        else if (state_q == S_DECODE) opc_q <= dec_op;
    end

    // Retired-instruction counter, wraps at full scale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          retired_q <= '0;
        else if (retire_evt) retired_q <= retired_q + 1'b1;
    end

    // Next-state selection and retire detection.
    always_comb begin
        state_d    = state_q;
        retire_evt = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_op == OP_HLT) begin
                    state_d    = S_HALT;
                    retire_evt = 1'b1;
                end else if (!is_legal(dec_op)) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc_q)
                    OP_ADD, OP_SUB, OP_AND: state_d = S_WB;
                    OP_LD, OP_ST:           state_d = S_MEM;
                    default: begin
                        state_d    = S_FETCH;
                        retire_evt = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opc_q == OP_ST) begin
                        state_d    = S_FETCH;
                        retire_evt = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_HALT, S_TRAP: begin
                if (run) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath enables decoded from state and latched opcode; all forced
    // low while reset is held so nothing reaches the datapath mid-reset.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        alu_op   = 2'b00;
        halted   = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            S_EXEC: begin
                alu_op = alu_code(opc_q);
                case (opc_q)
                    OP_LDI: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_IMM;
                    end
                    OP_JMP:  pc_load = 1'b1;
                    OP_BZ:   pc_load = alu_zero;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opc_q == OP_ST);
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = (opc_q == OP_LD) ? WB_MEM : WB_ALU;
                alu_op = alu_code(opc_q);
            end
            S_HALT: halted = 1'b1;
            S_TRAP: begin
                halted = 1'b1;
                trap   = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_load  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = WB_ALU;
            alu_op   = 2'b00;
            halted   = 1'b0;
            trap     = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
